reg_file_param: RTL
===================

Name: reg_file_param

Overview:
- Parametrised successor of the core register file.
- Holds NUM_GPR general-purpose registers, a stack pointer (SL/SH), a status register (Sreg) and a read-only view of the PC.
- Has two registered read ports and one byte/word write port.
- Stack pointer has native push/pop/load operations, so GPR writes no longer block on stack updates.
- Sits between decode/ALU and the data-memory stack path.

Parameters:
DATA_W, 8, register width in bits
NUM_GPR, 16, number of general-purpose registers (even, 2..32)
SEL_W, 5, select width; 2^SEL_W >= NUM_GPR+5
SP_RESET, 16'h00FF, stack pointer reset value (2*DATA_W bits)

Ports:
Clock  in  1  single rising-edge clock
Reset  in  1  asynchronous, active-high reset
RegS1Sel  in  SEL_W  read port 1 select
RegS1Out  out  DATA_W  read port 1 data, registered
RegS2Sel  in  SEL_W  read port 2 select
RegS2Out  out  DATA_W  read port 2 data, registered
RegEnable  in  1  byte write enable
RegInSel  in  SEL_W  write select
RegIn  in  DATA_W  byte write data
WordEnable  in  1  word write to pair RegInSel/RegInSel+1
WordIn  in  2*DATA_W  word data; low byte goes to the even register
StackOp  in  2  00 none, 01 push (SP-1), 10 pop (SP+1), 11 load StackIn
StackIn  in  2*DATA_W  SP load value
SpOut  out  2*DATA_W  current SP {SH,SL}
SregIn  in  DATA_W  status write data
SregMask  in  DATA_W  per-bit Sreg write enable
PCOut  in  2*DATA_W  program counter, read-only view
SregOut  out  DATA_W  current Sreg

Behaviour:
- Reset (async, any time, including mid-operation):
  - all GPRs = 0, Sreg = 0, SP = SP_RESET
  - RegS1Out = RegS2Out = 0
  - takes effect immediately; first update occurs on the first rising Clock edge after Reset deasserts.
- Select map:
  - 0..NUM_GPR-1: GPRs
  - NUM_GPR: SL; NUM_GPR+1: SH; NUM_GPR+2: Sreg; NUM_GPR+3: PCL; NUM_GPR+4: PCH
  - any higher code reads 0 and ignores writes.
- Reads:
  - 1-cycle latency: outputs capture the selected value on each rising edge.
  - Default is read-before-write: the old value is returned when a same-cycle write hits the same target.
  - PCL/PCH sample PCOut at that edge.
- Byte write: when RegEnable=1, the target at RegInSel is written on the edge. Sreg, PCL and PCH are not writable through this port.
- Word write:
  - WordEnable=1 with even RegInSel < NUM_GPR writes both registers.
  - Also allowed with RegInSel=NUM_GPR (SP pair).
  - Odd or out-of-range select: ignored.
  - WordEnable has priority over RegEnable.
- Stack:
  - StackOp is applied on the edge; arithmetic is modulo 2^(2*DATA_W), so push from 0 wraps to all-ones and pop from all-ones wraps to 0.
  - StackOp != 00 has priority over any byte/word write targeting SL/SH; that write is dropped.
  - GPR writes in the same cycle proceed normally.
- Sreg:
  - Sreg <= (Sreg & ~SregMask) | (SregIn & SregMask) every edge.
  - Mask 0 holds the value.
- SpOut and SregOut are driven directly from their registers, with no extra latency.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-first forwarding. If a read select matches a same-cycle write target (byte, word half, stack update of SL/SH, or masked Sreg), the read output captures the new value.
- Undefined: read-before-write as described above.

Decomposition:
- Package regfile_pkg holds:
  - select-offset localparams: SEL_SL, SEL_SH, SEL_SREG, SEL_PCL, SEL_PCH (relative to NUM_GPR)
  - StackOp codes: STK_NONE, STK_PUSH, STK_POP, STK_LOAD
- Sub-module sp_unit:
  - owns SP register, wrap arithmetic and SL/SH write arbitration
  - outputs SP and next-SP (next-SP is used by the bypass path).

Test Plan:
- Reset mid-stream with SP=0x1234 -> SpOut=0x00FF, reg0..15=0, RegS1Out=0, all asynchronously.
- Write reg5=0xA5, then read S1=5, S2=NUM_GPR+3 with PCOut=0xBEEF -> next cycle RegS1Out=0xA5, RegS2Out=0xEF.
- Word write RegInSel=6, WordIn=0x3C4D -> reg6=0x4D, reg7=0x3C; RegInSel=7 -> no change.
- SP=0x0000, push -> 0xFFFF; pop -> 0x0000; push plus byte write to SL the same cycle -> SL write dropped, GPR write to reg2 in the same cycle lands.
- Sreg=0xF0, SregIn=0x0F, SregMask=0x3C -> Sreg=0xCC.
- Write reg3=0x77 while reading sel 3 (old value 0x11) -> 0x11 without REGFILE_BYPASS_EN, 0x77 with it.

Source files
------------

// File: rtl/reg_file_param_pkg.sv
// Shared constants for the parametrised register file: select offsets past the GPRs and stack-pointer opcodes.
package regfile_pkg;

   // Offsets relative to NUM_GPR in the select map
   localparam int SEL_SL   = 0;
   localparam int SEL_SH   = 1;
   localparam int SEL_SREG = 2;
   localparam int SEL_PCL  = 3;
   localparam int SEL_PCH  = 4;
   localparam int SEL_NUM_SPECIAL = 5;

   typedef enum logic [1:0] {
      STK_NONE = 2'b00,
      STK_PUSH = 2'b01,
      STK_POP  = 2'b10,
      STK_LOAD = 2'b11
   } stk_op_t;

endpackage

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: two read ports, byte/word write port, stack control, Sreg update and PC view.
// master = decode/ALU side driving selects and data, slave = register file.
interface reg_file_param_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 5
);
   logic [SEL_W-1:0]    RegS1Sel;
   logic [DATA_W-1:0]   RegS1Out;
   logic [SEL_W-1:0]    RegS2Sel;
   logic [DATA_W-1:0]   RegS2Out;
   logic                RegEnable;
   logic [SEL_W-1:0]    RegInSel;
   logic [DATA_W-1:0]   RegIn;
   logic                WordEnable;
   logic [2*DATA_W-1:0] WordIn;
   logic [1:0]          StackOp;
   logic [2*DATA_W-1:0] StackIn;
   logic [2*DATA_W-1:0] SpOut;
   logic [DATA_W-1:0]   SregIn;
   logic [DATA_W-1:0]   SregMask;
   logic [2*DATA_W-1:0] PCOut;
   logic [DATA_W-1:0]   SregOut;

   modport master (
      output RegS1Sel, RegS2Sel, RegEnable, RegInSel, RegIn, WordEnable, WordIn,
             StackOp, StackIn, SregIn, SregMask, PCOut,
      input  RegS1Out, RegS2Out, SpOut, SregOut
   );

   modport slave (
      input  RegS1Sel, RegS2Sel, RegEnable, RegInSel, RegIn, WordEnable, WordIn,
             StackOp, StackIn, SregIn, SregMask, PCOut,
      output RegS1Out, RegS2Out, SpOut, SregOut
   );
endinterface

// File: rtl/reg_file_param_sp_unit.sv
// Stack pointer register with push/pop/load and SL/SH byte write arbitration (stack ops win).
// Updates on the clock edge; o_sp is the register, o_sp_nxt its combinational next value.
module sp_unit
   import regfile_pkg::*;
#(
   parameter int                  DATA_W   = 8,
   parameter logic [2*DATA_W-1:0] SP_RESET = 16'h00FF
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [1:0]          i_stack_op,
   input  logic [2*DATA_W-1:0] i_stack_in,
   input  logic                i_wr_sl,
   input  logic [DATA_W-1:0]   i_sl_dat,
   input  logic                i_wr_sh,
   input  logic [DATA_W-1:0]   i_sh_dat,
   output logic [2*DATA_W-1:0] o_sp,
   output logic [2*DATA_W-1:0] o_sp_nxt
);

   logic [2*DATA_W-1:0] r_sp;
   logic [2*DATA_W-1:0] w_sp_nxt;

   always_comb begin
      w_sp_nxt = r_sp;
      case (stk_op_t'(i_stack_op))
         STK_PUSH: w_sp_nxt = r_sp - 1'b1;
         STK_POP:  w_sp_nxt = r_sp + 1'b1;
         STK_LOAD: w_sp_nxt = i_stack_in;
         default: begin
            if (i_wr_sl) w_sp_nxt[DATA_W-1:0]        = i_sl_dat;
            if (i_wr_sh) w_sp_nxt[2*DATA_W-1:DATA_W] = i_sh_dat;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_sp <= SP_RESET;
      else       r_sp <= w_sp_nxt;
   end

   assign o_sp     = r_sp;
   assign o_sp_nxt = w_sp_nxt;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_GPR GPRs, SP, Sreg, PC view; 1-cycle registered reads, never stalls.
// REGFILE_BYPASS_EN selects write-first forwarding on reads; default is read-before-write.
module reg_file_param
   import regfile_pkg::*;
#(
   parameter int                  DATA_W   = 8,
   parameter int                  NUM_GPR  = 16,
   parameter int                  SEL_W    = 5,
   parameter logic [2*DATA_W-1:0] SP_RESET = 16'h00FF
) (
   input  logic             Clock,
   input  logic             Reset,
   reg_file_param_if.slave  bus
);

   localparam int NUM_VIEW = NUM_GPR + SEL_NUM_SPECIAL;

   logic [DATA_W-1:0]   r_gpr [NUM_GPR];
   logic [DATA_W-1:0]   r_sreg;
   logic [DATA_W-1:0]   r_s1;
   logic [DATA_W-1:0]   r_s2;

   logic [DATA_W-1:0]   w_gpr_nxt [NUM_GPR];
   logic [DATA_W-1:0]   w_sreg_nxt;
   logic [DATA_W-1:0]   w_view [NUM_VIEW];
   logic [2*DATA_W-1:0] w_sp;
   logic [2*DATA_W-1:0] w_sp_nxt;
   logic                w_byte_en;
   logic                w_word_ok;
   logic                w_wr_sl;
   logic                w_wr_sh;
   logic [DATA_W-1:0]   w_sl_dat;
   logic [DATA_W-1:0]   w_sh_dat;
   int                  w_wsel;

   assign w_wsel    = int'(bus.RegInSel);
   assign w_byte_en = bus.RegEnable && !bus.WordEnable;
   // Word writes need an even GPR pair or the SP pair; anything else is dropped
   assign w_word_ok = bus.WordEnable &&
                      ((w_wsel < NUM_GPR && !bus.RegInSel[0]) || w_wsel == NUM_GPR + SEL_SL);

   assign w_wr_sl  = (w_word_ok && w_wsel == NUM_GPR + SEL_SL) ||
                     (w_byte_en && w_wsel == NUM_GPR + SEL_SL);
   assign w_wr_sh  = (w_word_ok && w_wsel == NUM_GPR + SEL_SL) ||
                     (w_byte_en && w_wsel == NUM_GPR + SEL_SH);
   assign w_sl_dat = bus.WordEnable ? bus.WordIn[DATA_W-1:0]        : bus.RegIn;
   assign w_sh_dat = bus.WordEnable ? bus.WordIn[2*DATA_W-1:DATA_W] : bus.RegIn;

   always_comb begin
      for (int i = 0; i < NUM_GPR; i++) begin
         w_gpr_nxt[i] = r_gpr[i];
         if (w_byte_en && w_wsel == i)
            w_gpr_nxt[i] = bus.RegIn;
         if (w_word_ok && (i % 2 == 0) && w_wsel == i)
            w_gpr_nxt[i] = bus.WordIn[DATA_W-1:0];
         if (w_word_ok && (i % 2 == 1) && w_wsel == i - 1)
            w_gpr_nxt[i] = bus.WordIn[2*DATA_W-1:DATA_W];
      end
   end

   assign w_sreg_nxt = (r_sreg & ~bus.SregMask) | (bus.SregIn & bus.SregMask);

   sp_unit #(
      .DATA_W   (DATA_W),
      .SP_RESET (SP_RESET)
   ) u_sp (
      .Clock      (Clock),
      .Reset      (Reset),
      .i_stack_op (bus.StackOp),
      .i_stack_in (bus.StackIn),
      .i_wr_sl    (w_wr_sl),
      .i_sl_dat   (w_sl_dat),
      .i_wr_sh    (w_wr_sh),
      .i_sh_dat   (w_sh_dat),
      .o_sp       (w_sp),
      .o_sp_nxt   (w_sp_nxt)
   );

   always_comb begin
      for (int i = 0; i < NUM_GPR; i++) begin
`ifdef REGFILE_BYPASS_EN
         w_view[i] = w_gpr_nxt[i];
`else
         w_view[i] = r_gpr[i];
`endif
      end
`ifdef REGFILE_BYPASS_EN
      w_view[NUM_GPR + SEL_SL]   = w_sp_nxt[DATA_W-1:0];
      w_view[NUM_GPR + SEL_SH]   = w_sp_nxt[2*DATA_W-1:DATA_W];
      w_view[NUM_GPR + SEL_SREG] = w_sreg_nxt;
`else
      w_view[NUM_GPR + SEL_SL]   = w_sp[DATA_W-1:0];
      w_view[NUM_GPR + SEL_SH]   = w_sp[2*DATA_W-1:DATA_W];
      w_view[NUM_GPR + SEL_SREG] = r_sreg;
`endif
      w_view[NUM_GPR + SEL_PCL]  = bus.PCOut[DATA_W-1:0];
      w_view[NUM_GPR + SEL_PCH]  = bus.PCOut[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
         r_sreg <= '0;
         r_s1   <= '0;
         r_s2   <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= w_gpr_nxt[i];
         r_sreg <= w_sreg_nxt;
         r_s1   <= (int'(bus.RegS1Sel) < NUM_VIEW) ? w_view[bus.RegS1Sel] : '0;
         r_s2   <= (int'(bus.RegS2Sel) < NUM_VIEW) ? w_view[bus.RegS2Sel] : '0;
      end
   end

   assign bus.RegS1Out = r_s1;
   assign bus.RegS2Out = r_s2;
   assign bus.SpOut    = w_sp;
   assign bus.SregOut  = r_sreg;

endmodule
